// File: rtl/div_unit_pkg.sv
// div_unit_pkg: divider state encodings, handshake levels and shared constants
package div_unit_pkg;
   localparam int         DivWidth          = 32;
   localparam logic       RstEnable         = 1'b1;
   localparam logic [1:0] DivFree           = 2'b00;
   localparam logic [1:0] DivByZero         = 2'b01;
   localparam logic [1:0] DivOn             = 2'b10;
   localparam logic [1:0] DivEnd            = 2'b11;
   localparam logic       DivResultReady    = 1'b1;
   localparam logic       DivResultNotReady = 1'b0;
   localparam logic       DivStart          = 1'b1;
   localparam logic       DivStop           = 1'b0;
   localparam logic [DivWidth-1:0] ZeroWord = '0;
   typedef enum logic [1:0] {
      DIV_FREE    = DivFree,
      DIV_BY_ZERO = DivByZero,
      DIV_ON      = DivOn,
      DIV_END     = DivEnd
   } div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX <-> divider request/result bundle
//   master (EX):      drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i; reads result_o, ready_o
//   slave (divider):  the reverse
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DivWidth
);
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );
   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU, result {remainder, quotient}
//   clk, rst  clock, synchronous active-high reset
//   bus       div_unit_if.slave: operands, start/annul in; registered result_o/ready_o out
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DivWidth
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction
   div_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;
   logic               neg1, neg2, qbit;
   logic [WIDTH-1:0]   trial, rem_n, quo_n;
   // The dividend register shifts left each iteration and collects quotient bits in its LSB.
   // The comparison uses the full shifted remainder (WIDTH+1 bits) so divisors >= 2^(WIDTH-1)
   // are handled; the subtraction itself fits in WIDTH bits whenever it is taken.
   always_comb begin
      neg1  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      neg2  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      qbit  = {rem_q, dvd_q[WIDTH-1]} >= {1'b0, dvs_q};
      trial = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} - dvs_q;
      rem_n = qbit ? trial : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
      quo_n = {dvd_q[WIDTH-2:0], qbit};
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = ready_q;
      unique case (state_q)
         DIV_FREE: begin
            result_d = {ZeroWord, ZeroWord};
            ready_d  = DivResultNotReady;
            if (bus.start_i == DivStart && !bus.annul_i) begin
               if (bus.opdata2_i == ZeroWord) begin
                  state_d = DIV_BY_ZERO;
               end else begin
                  state_d = DIV_ON;
                  dvd_d   = neg1 ? negate(bus.opdata1_i) : bus.opdata1_i;
                  dvs_d   = neg2 ? negate(bus.opdata2_i) : bus.opdata2_i;
                  qneg_d  = neg1 ^ neg2;
                  rneg_d  = neg1;
                  cnt_d   = '0;
                  rem_d   = ZeroWord;
               end
            end
         end
         DIV_BY_ZERO: begin
            state_d  = bus.annul_i ? DIV_FREE : DIV_END;
            ready_d  = bus.annul_i ? DivResultNotReady : DivResultReady;
            result_d = {ZeroWord, ZeroWord};
         end
         DIV_ON: begin
            if (bus.annul_i) begin
               state_d  = DIV_FREE;
               ready_d  = DivResultNotReady;
               result_d = {ZeroWord, ZeroWord};
            end else begin
               dvd_d = quo_n;
               rem_d = rem_n;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d  = DIV_END;
                  ready_d  = DivResultReady;
                  result_d = {rneg_q ? negate(rem_n) : rem_n, qneg_q ? negate(quo_n) : quo_n};
               end
            end
         end
         DIV_END: begin
            if (bus.start_i == DivStop) begin
               state_d  = DIV_FREE;
               ready_d  = DivResultNotReady;
               result_d = {ZeroWord, ZeroWord};
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end
   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomised self-checking bench for div_unit
module tb_div_unit;
   import div_unit_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   div_unit_if #(.WIDTH(32)) bus ();
   div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Drives one request and waits (bounded) for ready_o; lat is the edge count with the
   // sampling edge as 1, or 0 if ready never appeared.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      lat = 0;
      res = '0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.ready_o === 1'b1) begin
            lat = i;
            res = bus.result_o;
            break;
         end
      end
   endtask
   task automatic finish_op();
      bus.start_i = 1'b0;
      step();
   endtask
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return 64'h0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = {32'h0, a};
         sb = {32'h0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction
   task automatic test_reset();
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset ready: got %b expected 0", bus.ready_o); end
      checks++;
      if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset result: got %h expected 0", bus.result_o); end
      rst = 1'b0;
      step();
   endtask
   task automatic test_divu_basic();
      logic [63:0] r;
      int l;
      run_op(1'b0, 32'd100, 32'd7, r, l);
      checks++;
      if (l !== 33) begin errors++; $display("FAIL divu_100_7 latency: got %0d expected 33", l); end
      checks++;
      if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_100_7 result: got %h expected %h", r, 64'h00000002_0000000E); end
      step();
      checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
         errors++; $display("FAIL divu_hold: got ready=%b result=%h expected ready=1 result=%h", bus.ready_o, bus.result_o, 64'h00000002_0000000E);
      end
      finish_op();
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++; $display("FAIL divu_release: got ready=%b result=%h expected ready=0 result=0", bus.ready_o, bus.result_o);
      end
   endtask
   task automatic test_signed();
      logic [63:0] r;
      int l;
      run_op(1'b1, 32'hFFFFFF9C, 32'd7, r, l);
      checks++;
      if (r !== 64'hFFFFFFFE_FFFFFFF2) begin errors++; $display("FAIL div_m100_7: got %h expected %h", r, 64'hFFFFFFFE_FFFFFFF2); end
      finish_op();
      run_op(1'b1, 32'd100, 32'hFFFFFFF9, r, l);
      checks++;
      if (r !== 64'h00000002_FFFFFFF2) begin errors++; $display("FAIL div_100_m7: got %h expected %h", r, 64'h00000002_FFFFFFF2); end
      checks++;
      if (l !== 33) begin errors++; $display("FAIL div_100_m7 latency: got %0d expected 33", l); end
      finish_op();
   endtask
   task automatic test_boundaries();
      logic [63:0] r;
      int l;
      run_op(1'b1, 32'd5, 32'd0, r, l);
      checks++;
      if (l !== 2) begin errors++; $display("FAIL div_zero latency: got %0d expected 2", l); end
      checks++;
      if (r !== 64'h0) begin errors++; $display("FAIL div_zero result: got %h expected 0", r); end
      finish_op();
      run_op(1'b0, 32'hFFFFFFFF, 32'd1, r, l);
      checks++;
      if (r !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL divu_max_1: got %h expected %h", r, 64'h00000000_FFFFFFFF); end
      finish_op();
      run_op(1'b0, 32'hFFFFFFFF, 32'h80000000, r, l);
      checks++;
      if (r !== 64'h7FFFFFFF_00000001) begin errors++; $display("FAIL divu_max_big: got %h expected %h", r, 64'h7FFFFFFF_00000001); end
      finish_op();
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, r, l);
      checks++;
      if (r !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow: got %h expected %h", r, 64'h00000000_80000000); end
      checks++;
      if (l !== 33) begin errors++; $display("FAIL div_overflow latency: got %0d expected 33", l); end
      finish_op();
   endtask
   task automatic test_annul();
      logic [63:0] r;
      int l;
      int seen;
      bus.signed_div_i = 1'b1;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      for (int i = 0; i < 11; i++) step();
      bus.annul_i = 1'b1;
      step();
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      checks++;
      if (dut.state_q !== DIV_FREE) begin errors++; $display("FAIL annul_state: got %0d expected %0d", dut.state_q, DIV_FREE); end
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++; $display("FAIL annul_outputs: got ready=%b result=%h expected ready=0 result=0", bus.ready_o, bus.result_o);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.ready_o !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen); end
      run_op(1'b0, 32'd9, 32'd3, r, l);
      checks++;
      if (r !== 64'h00000000_00000003) begin errors++; $display("FAIL after_annul result: got %h expected %h", r, 64'h3); end
      checks++;
      if (l !== 33) begin errors++; $display("FAIL after_annul latency: got %0d expected 33", l); end
      finish_op();
   endtask
   task automatic test_reset_mid();
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd12345;
      bus.opdata2_i    = 32'd17;
      bus.start_i      = 1'b1;
      for (int i = 0; i < 21; i++) step();
      rst = 1'b1;
      bus.start_i = 1'b0;
      step();
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++; $display("FAIL reset_mid outputs: got ready=%b result=%h expected ready=0 result=0", bus.ready_o, bus.result_o);
      end
      checks++;
      if (dut.state_q !== DIV_FREE) begin errors++; $display("FAIL reset_mid state: got %0d expected %0d", dut.state_q, DIV_FREE); end
      rst = 1'b0;
      step();
   endtask
   task automatic test_random_operand_change();
      logic        sgn;
      logic [31:0] a, b;
      logic [63:0] exp, r;
      int          l;
      for (int n = 0; n < 12; n++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom();
         b   = (n % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom();
         if (n == 5) b = 32'hFFFFFFFF;
         exp = ref_div(sgn, a, b);
         bus.signed_div_i = sgn;
         bus.opdata1_i    = a;
         bus.opdata2_i    = b;
         bus.start_i      = 1'b1;
         step();
         bus.signed_div_i = ~sgn;
         bus.opdata1_i    = $urandom();
         bus.opdata2_i    = $urandom();
         l = 0;
         r = '0;
         for (int i = 2; i <= 40; i++) begin
            step();
            if (i == 17) bus.opdata1_i = ~bus.opdata1_i;
            if (bus.ready_o === 1'b1) begin
               l = i;
               r = bus.result_o;
               break;
            end
         end
         checks++;
         if (r !== exp || l != 33) begin
            errors++; $display("FAIL random_%0d sgn=%b a=%h b=%h: got %h lat %0d expected %h lat 33", n, sgn, a, b, r, l, exp);
         end
         finish_op();
      end
   endtask
   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_boundaries();
      test_annul();
      test_reset_mid();
      test_random_operand_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
